dsi_stream_arbiter: RTL and testbench

//  Shares the 32-bit DSI packet path between two Avalon-ST sources at packet granularity:
//   - the packed-pixel video stream from the 24->32 packer;
//   - a command-packet stream (DCS/generic writes from the register block).

---
 rtl/dsi_arb_pkg.sv | 27 ++
 rtl/dsi_stream_arbiter.sv | 128 ++++++++++++
 tb/tb_dsi_stream_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsi_arb_pkg.sv
// Shared encodings for the DSI packet-path arbiter: FSM states, source IDs and
// the width of the command-burst counter.
package dsi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_CMD  = 2'd2
  } arb_state_e;

  localparam logic SRC_VID = 1'b0;
  localparam logic SRC_CMD = 1'b1;
  localparam int   CNT_W   = 4;

  // Burst counter increment that holds at the configured ceiling
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] max_v);
    logic [CNT_W-1:0] r;
    if (v < max_v) begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r = max_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsi_stream_arbiter.sv
// Packet-granular arbiter sharing the 32-bit DSI packet path between the packed
// video stream and the command stream; commands slot in only between video packets.
module dsi_stream_arbiter
  import dsi_arb_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int CMD_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_valid,
  input  logic              vid_sop,
  input  logic              vid_eop,
  output logic              vid_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_valid,
  input  logic              cmd_sop,
  input  logic              cmd_eop,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_src,
  input  logic              out_ready,
  input  logic              cfg_video_en,
  output logic [1:0]        stat_state,
  output logic              err_orphan
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(CMD_BURST_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic             vreq_s, creq_s;

  // Arbitration, zero-latency forwarding mux and orphan draining
  always_comb begin
    state_d    = state_q;
    cmd_cnt_d  = cmd_cnt_q;
    out_data   = '0;
    out_valid  = 1'b0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    out_src    = SRC_VID;
    vid_ready  = 1'b0;
    cmd_ready  = 1'b0;
    err_orphan = 1'b0;
    vreq_s     = vid_valid & vid_sop & cfg_video_en;
    creq_s     = cmd_valid & cmd_sop;
    case (state_q)
      ST_IDLE: begin
        // Draining is gated by rst_n so every output reads 0 while reset is held
        if (rst_n) begin
          if (vid_valid && !vid_sop && cfg_video_en) begin
            vid_ready  = 1'b1;
            err_orphan = 1'b1;
          end else begin
            vid_ready  = 1'b0;
          end
          if (cmd_valid && !cmd_sop) begin
            cmd_ready  = 1'b1;
            err_orphan = 1'b1;
          end else begin
            cmd_ready  = 1'b0;
          end
        end else begin
          err_orphan = 1'b0;
        end
        if (creq_s && (cmd_cnt_q < BURST_MAX)) begin
          state_d = ST_CMD;
        end else if (vreq_s) begin
          state_d = ST_VID;
        end else if (creq_s) begin
          state_d = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VID: begin
        out_valid = vid_valid;
        out_data  = vid_valid ? vid_data : '0;
        out_sop   = vid_valid & vid_sop;
        out_eop   = vid_valid & vid_eop;
        out_src   = SRC_VID;
        vid_ready = out_ready;
        if (vid_valid && out_ready && vid_eop) begin
          state_d   = ST_IDLE;
          cmd_cnt_d = '0;
        end else begin
          state_d   = ST_VID;
        end
      end
      ST_CMD: begin
        out_valid = cmd_valid;
        out_data  = cmd_valid ? cmd_data : '0;
        out_sop   = cmd_valid & cmd_sop;
        out_eop   = cmd_valid & cmd_eop;
        out_src   = cmd_valid ? SRC_CMD : SRC_VID;
        cmd_ready = out_ready;
        if (cmd_valid && out_ready && cmd_eop) begin
          state_d   = ST_IDLE;
          cmd_cnt_d = sat_inc(cmd_cnt_q, BURST_MAX);
        end else begin
          state_d   = ST_CMD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and command-burst counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_cnt_q <= cmd_cnt_d;
    end
  end

  assign stat_state = state_q;

endmodule

// File: tb/tb_dsi_stream_arbiter.sv
// Scoreboard bench for dsi_stream_arbiter: directed packets are queued at the
// sources, expected output beats are queued in order, and a monitor pops/compares.
module tb_dsi_stream_arbiter;
  import dsi_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] vid_data, cmd_data, out_data;
  logic        vid_valid, vid_sop, vid_eop, vid_ready;
  logic        cmd_valid, cmd_sop, cmd_eop, cmd_ready;
  logic        out_valid, out_sop, out_eop, out_src, out_ready;
  logic        cfg_video_en, err_orphan;
  logic [1:0]  stat_state;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t vq[$];
  beat_t cq[$];
  beat_t sbq[$];
  int compared   = 0;
  int mismatched = 0;

  dsi_stream_arbiter #(.DATA_W(32), .CMD_BURST_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_data(vid_data), .vid_valid(vid_valid), .vid_sop(vid_sop), .vid_eop(vid_eop),
    .vid_ready(vid_ready),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
    .cmd_ready(cmd_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_src(out_src), .out_ready(out_ready),
    .cfg_video_en(cfg_video_en), .stat_state(stat_state), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_v(input logic [31:0] d, input logic s, input logic e, input bit expect_out);
    beat_t b;
    b.src = SRC_VID; b.data = d; b.sop = s; b.eop = e;
    vq.push_back(b);
    if (expect_out) sbq.push_back(b);
  endtask

  task automatic push_c(input logic [31:0] d, input logic s, input logic e, input bit expect_out);
    beat_t b;
    b.src = SRC_CMD; b.data = d; b.sop = s; b.eop = e;
    cq.push_back(b);
    if (expect_out) sbq.push_back(b);
  endtask

  task automatic expect_beat(input logic src, input logic [31:0] d, input logic s, input logic e);
    beat_t b;
    b.src = src; b.data = d; b.sop = s; b.eop = e;
    sbq.push_back(b);
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while (sbq.size() != 0 && n < maxc) begin
      @(posedge clk); #2;
      n++;
    end
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d beats still pending after %0d cycles, expected 0",
               name, sbq.size(), maxc);
      sbq.delete();
    end
  endtask

  // Source models: present queue heads, pop on handshake
  initial begin : drivers
    bit fv, fc;
    vid_valid = 1'b0; vid_data = 32'd0; vid_sop = 1'b0; vid_eop = 1'b0;
    cmd_valid = 1'b0; cmd_data = 32'd0; cmd_sop = 1'b0; cmd_eop = 1'b0;
    forever begin
      @(negedge clk);
      fv = vid_valid && vid_ready;
      fc = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      if (fv && vq.size() > 0) void'(vq.pop_front());
      if (fc && cq.size() > 0) void'(cq.pop_front());
      if (vq.size() > 0) begin
        vid_valid = 1'b1; vid_data = vq[0].data; vid_sop = vq[0].sop; vid_eop = vq[0].eop;
      end else begin
        vid_valid = 1'b0; vid_data = 32'd0; vid_sop = 1'b0; vid_eop = 1'b0;
      end
      if (cq.size() > 0) begin
        cmd_valid = 1'b1; cmd_data = cq[0].data; cmd_sop = cq[0].sop; cmd_eop = cq[0].eop;
      end else begin
        cmd_valid = 1'b0; cmd_data = 32'd0; cmd_sop = 1'b0; cmd_eop = 1'b0;
      end
    end
  end

  // Monitor: every accepted output beat must match the scoreboard head
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got data 0x%0h src %0d, expected no beat", out_data, out_src);
        end else begin
          e = sbq.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_src", 32'(out_src), 32'(e.src));
          chk("out_sop", 32'(out_sop), 32'(e.sop));
          chk("out_eop", 32'(out_eop), 32'(e.eop));
        end
      end
      if (!out_valid) chk("out_zero_when_invalid", {out_data[31:3], out_sop, out_eop, out_src}, 32'd0);
    end
  end

  initial begin : main
    logic [1:0]  t1_exp [5];
    logic        stalled;
    logic [31:0] prev_d;
    bit          hit;
    t1_exp = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};

    rst_n = 1'b0; out_ready = 1'b1; cfg_video_en = 1'b1;
    #3;
    chk("rst_state", 32'(stat_state), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_vid_ready", 32'(vid_ready), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_err_orphan", 32'(err_orphan), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: video-only 3-beat frame
    @(posedge clk); #2;
    push_v(32'h1111_0000, 1'b1, 1'b0, 1'b1);
    push_v(32'h1111_0001, 1'b0, 1'b0, 1'b1);
    push_v(32'h1111_0002, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_state", 32'(stat_state), 32'(t1_exp[i]));
      if (i == 0) chk("t1_no_fwd_in_idle", 32'(out_valid), 32'd0);
      if (i == 1) chk("t1_out_valid_next", 32'(out_valid), 32'd1);
    end
    wait_drain("t1", 20);

    // 2: both sops pending, burst budget 2 -> C0, C1, video, C2
    @(posedge clk); #2;
    push_c(32'hC000_0001, 1'b1, 1'b1, 1'b0);
    push_c(32'hC000_0002, 1'b1, 1'b1, 1'b0);
    push_c(32'hC000_0003, 1'b1, 1'b1, 1'b0);
    push_v(32'h2222_0000, 1'b1, 1'b0, 1'b0);
    push_v(32'h2222_0001, 1'b0, 1'b1, 1'b0);
    expect_beat(SRC_CMD, 32'hC000_0001, 1'b1, 1'b1);
    expect_beat(SRC_CMD, 32'hC000_0002, 1'b1, 1'b1);
    expect_beat(SRC_VID, 32'h2222_0000, 1'b1, 1'b0);
    expect_beat(SRC_VID, 32'h2222_0001, 1'b0, 1'b1);
    expect_beat(SRC_CMD, 32'hC000_0003, 1'b1, 1'b1);
    wait_drain("t2", 40);

    // 3: 4-beat command packet with out_ready toggling
    @(posedge clk); #2;
    push_c(32'hD000_0000, 1'b1, 1'b0, 1'b1);
    push_c(32'hD000_0001, 1'b0, 1'b0, 1'b1);
    push_c(32'hD000_0002, 1'b0, 1'b0, 1'b1);
    push_c(32'hD000_0003, 1'b0, 1'b1, 1'b1);
    stalled = 1'b0;
    prev_d  = 32'd0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #2;
      out_ready = (i % 2 == 0);
      @(negedge clk);
      if (stat_state == 2'd2) chk("t3_ready_mirror", 32'(cmd_ready), 32'(out_ready));
      if (stalled) chk("t3_hold_data", out_data, prev_d);
      stalled = (stat_state == 2'd2) && out_valid && !out_ready;
      prev_d  = out_data;
    end
    @(posedge clk); #2 out_ready = 1'b1;
    wait_drain("t3", 20);

    // 4: command orphan in IDLE
    @(posedge clk); #2;
    push_c(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_err_orphan", 32'(err_orphan), 32'd1);
    chk("t4_state", 32'(stat_state), 32'd0);
    @(negedge clk);
    chk("t4_err_pulse_end", 32'(err_orphan), 32'd0);
    chk("t4_drained_once", 32'(cmd_valid), 32'd0);

    // 5: cfg_video_en cleared mid-frame
    @(posedge clk); #2;
    push_v(32'hE000_0000, 1'b1, 1'b0, 1'b1);
    push_v(32'hE000_0001, 1'b0, 1'b0, 1'b1);
    push_v(32'hE000_0002, 1'b0, 1'b0, 1'b1);
    push_v(32'hE000_0003, 1'b0, 1'b1, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (stat_state == 2'd1) hit = 1'b1;
    end
    chk("t5_vid_granted", 32'(hit), 32'd1);
    @(posedge clk); #2;
    cfg_video_en = 1'b0;
    push_v(32'hF000_0000, 1'b1, 1'b0, 1'b0);
    push_v(32'hF000_0001, 1'b0, 1'b1, 1'b0);
    push_c(32'hC5C5_0001, 1'b1, 1'b1, 1'b1);
    wait_drain("t5", 30);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_vid_held_ready", 32'(vid_ready), 32'd0);
      chk("t5_vid_held_state", 32'(stat_state), 32'd0);
    end
    @(posedge clk); #2;
    cfg_video_en = 1'b1;
    expect_beat(SRC_VID, 32'hF000_0000, 1'b1, 1'b0);
    expect_beat(SRC_VID, 32'hF000_0001, 1'b0, 1'b1);
    wait_drain("t5b", 20);

    // 6: reset on beat 2 of a 5-beat video frame
    @(posedge clk); #2;
    push_v(32'h6000_0000, 1'b1, 1'b0, 1'b1);
    push_v(32'h6000_0001, 1'b0, 1'b0, 1'b1);
    push_v(32'h6000_0002, 1'b0, 1'b0, 1'b0);
    push_v(32'h6000_0003, 1'b0, 1'b0, 1'b0);
    push_v(32'h6000_0004, 1'b0, 1'b1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(posedge clk); #2;
      if (sbq.size() == 0) hit = 1'b1;
    end
    chk("t6_two_beats_out", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_state", 32'(stat_state), 32'd0);
    chk("t6_rst_vid_ready", 32'(vid_ready), 32'd0);
    vq.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    push_c(32'h7000_0000, 1'b1, 1'b0, 1'b1);
    push_c(32'h7000_0001, 1'b0, 1'b1, 1'b1);
    wait_drain("t6", 20);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
